// File: rtl/axil_cfg_regs.sv
// AXI4-Lite register file: index 0 is a read-only ID word, indices 1..NUM_REGS-1 are RW.
// AW and W each go into a one-entry hold, and a write commits once both holds are full.
module axil_cfg_regs #(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned REG_ADDR_BITS = 12,
  parameter logic [31:0] ID_VALUE      = 32'h4D4E5348,
  parameter logic [31:0] RESET_VALUE   = 32'h00000000
) (
  input  logic                      axil_aclk,
  input  logic                      axil_aresetn,
  input  logic                      s_axil_awvalid,
  input  logic [31:0]               s_axil_awaddr,
  output logic                      s_axil_awready,
  input  logic                      s_axil_wvalid,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  output logic                      s_axil_wready,
  output logic                      s_axil_bvalid,
  output logic [1:0]                s_axil_bresp,
  input  logic                      s_axil_bready,
  input  logic                      s_axil_arvalid,
  input  logic [31:0]               s_axil_araddr,
  output logic                      s_axil_arready,
  output logic                      s_axil_rvalid,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  input  logic                      s_axil_rready,
  output logic [NUM_REGS*32-1:0]    cfg_regs,
  output logic [NUM_REGS-1:0]       cfg_wr_stb
);

  localparam int unsigned IdxW = REG_ADDR_BITS - 2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  logic                aw_held_q;
  logic [IdxW-1:0]     aw_idx_q;
  logic                w_held_q;
  logic [31:0]         w_data_q;
  logic [3:0]          w_strb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic [31:0]         regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] wr_stb_q;

  logic                aw_hs, w_hs, ar_hs, wr_commit;
  logic [IdxW-1:0]     ar_idx;
  logic [NUM_REGS-1:0] wr_sel;
  logic [1:0]          wr_resp;
  logic [31:0]         rd_data;
  logic [1:0]          rd_resp;

  // Only the offset inside the 4 KB window is decoded; the interconnect owns the rest.
  logic unused_addr;
  assign unused_addr = ^{s_axil_awaddr[31:REG_ADDR_BITS], s_axil_awaddr[1:0],
                         s_axil_araddr[31:REG_ADDR_BITS], s_axil_araddr[1:0]};

  assign s_axil_awready = axil_aresetn & ~aw_held_q;
  assign s_axil_wready  = axil_aresetn & ~w_held_q;
  assign s_axil_arready = axil_aresetn & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign cfg_wr_stb     = wr_stb_q;

  assign aw_hs     = s_axil_awvalid & s_axil_awready;
  assign w_hs      = s_axil_wvalid & s_axil_wready;
  assign ar_hs     = s_axil_arvalid & s_axil_arready;
  assign wr_commit = aw_held_q & w_held_q & (~bvalid_q | s_axil_bready);
  assign ar_idx    = s_axil_araddr[REG_ADDR_BITS-1:2];

  always_comb begin
    wr_sel  = '0;
    wr_resp = RespDecErr;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (32'(aw_idx_q) == i);
    end
    if (wr_sel[0]) begin
      wr_resp = RespSlvErr;
    end else if (|wr_sel) begin
      wr_resp = RespOkay;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespDecErr;
    if (32'(ar_idx) == 32'd0) begin
      rd_data = ID_VALUE;
      rd_resp = RespOkay;
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == i) begin
        rd_data = regs_q[i];
        rd_resp = RespOkay;
      end
    end
  end

  always_comb begin
    cfg_regs       = '0;
    cfg_regs[31:0] = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      cfg_regs[32*i +: 32] = regs_q[i];
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[REG_ADDR_BITS-1:2];
      end else if (wr_commit) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end else if (wr_commit) begin
        w_held_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
      wr_stb_q <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      wr_stb_q <= '0;
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (wr_resp == RespOkay) begin
          wr_stb_q <= wr_sel;
          for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
              for (int k = 0; k < 4; k++) begin
                if (w_strb_q[k]) regs_q[i][8*k +: 8] <= w_data_q[8*k +: 8];
              end
            end
          end
        end
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read samples regs_q before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_cfg_regs.sv
// Directed bench for axil_cfg_regs: handshake timing, byte strobes, error responses,
// back-pressure and reset in the middle of a write.
module tb_axil_cfg_regs;

  localparam logic [31:0] Id = 32'h4D4E5348;

  logic        axil_aclk, axil_aresetn;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_awaddr;
  logic        s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_araddr;
  logic        s_axil_rvalid, s_axil_rready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic [255:0] cfg_regs;
  logic [7:0]  cfg_wr_stb;

  int n_checks = 0;
  int n_fails  = 0;
  int stb_cnt [8];

  axil_cfg_regs dut (
    .axil_aclk      (axil_aclk),
    .axil_aresetn   (axil_aresetn),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bready  (s_axil_bready),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arready (s_axil_arready),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rready  (s_axil_rready),
    .cfg_regs       (cfg_regs),
    .cfg_wr_stb     (cfg_wr_stb)
  );

  initial begin
    axil_aclk = 1'b0;
    forever #5 axil_aclk = ~axil_aclk;
  end

  always @(negedge axil_aclk) begin
    for (int i = 0; i < 8; i++) if (cfg_wr_stb[i]) stb_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int stb_total();
    int s = 0;
    for (int i = 0; i < 8; i++) s += stb_cnt[i];
    return s;
  endfunction

  // Starts and ends just after a rising edge.
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got_b;
    int n;
    aw_done = 0; w_done = 0; got_b = 0; n = 0; resp = 2'b01;
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge axil_aclk);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(posedge axil_aclk); #1;
      if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin s_axil_wvalid = 1'b0; w_done = 1; end
      n++;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!got_b && n < 50) begin
      @(negedge axil_aclk);
      if (s_axil_bvalid) begin got_b = 1; resp = s_axil_bresp; end
      @(posedge axil_aclk); #1;
      n++;
    end
    check("wr_bvalid", got_b, 1'b1);
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    bit done, hs;
    int n;
    done = 0; n = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    while (!done && n < 50) begin
      @(negedge axil_aclk);
      hs = s_axil_arvalid && s_axil_arready;
      @(posedge axil_aclk); #1;
      if (hs) begin s_axil_arvalid = 1'b0; done = 1; end
      n++;
    end
    s_axil_arvalid = 1'b0;
    check("rd_accept", done, 1'b1);
    @(negedge axil_aclk);
    check("rd_latency", s_axil_rvalid, 1'b1);
    data = s_axil_rdata; resp = s_axil_rresp;
    @(posedge axil_aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          tot;
    for (int i = 0; i < 8; i++) stb_cnt[i] = 0;
    axil_aresetn = 1'b0;
    s_axil_awvalid = 0; s_axil_awaddr = 0; s_axil_wvalid = 0; s_axil_wdata = 0;
    s_axil_wstrb = 0; s_axil_bready = 1; s_axil_arvalid = 0; s_axil_araddr = 0;
    s_axil_rready = 1;

    // Reset state
    @(negedge axil_aclk);
    check("rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    check("rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    check("rst_id", cfg_regs[31:0], Id);
    check("rst_reg1", cfg_regs[63:32], 32'h0);
    check("rst_rdata", s_axil_rdata, 32'h0);
    repeat (2) @(posedge axil_aclk);
    #1 axil_aresetn = 1'b1;

    // AW and W together: commit one edge after handshake, awready low one cycle
    s_axil_awaddr = 32'h1004; s_axil_awvalid = 1; s_axil_wdata = 32'h1;
    s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    @(negedge axil_aclk);
    check("t1_awready_idle", s_axil_awready, 1'b1);
    @(posedge axil_aclk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    @(negedge axil_aclk);
    check("t1_awready_held", s_axil_awready, 1'b0);
    check("t1_no_b_yet", s_axil_bvalid, 1'b0);
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("t1_b", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    check("t1_awready_back", s_axil_awready, 1'b1);
    check("t1_stb", cfg_wr_stb, 8'h02);
    check("t1_reg1", cfg_regs[63:32], 32'h1);
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("t1_b_done", s_axil_bvalid, 1'b0);
    check("t1_stb_off", cfg_wr_stb, 8'h00);
    @(posedge axil_aclk); #1;
    check("t1_stb_count", stb_cnt[1], 1);

    // W three cycles before AW
    s_axil_wdata = 32'h00020001; s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    @(posedge axil_aclk); #1;
    s_axil_wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge axil_aclk);
      check("t2_no_commit", {s_axil_bvalid, s_axil_wready}, 2'b00);
      @(posedge axil_aclk); #1;
    end
    s_axil_awaddr = 32'h2008; s_axil_awvalid = 1;
    @(negedge axil_aclk);
    check("t2_awready", s_axil_awready, 1'b1);
    @(posedge axil_aclk); #1;
    s_axil_awvalid = 0;
    @(negedge axil_aclk);
    check("t2_b_next_edge", s_axil_bvalid, 1'b0);
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("t2_b", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    @(posedge axil_aclk); #1;
    axil_read(32'h2008, d, r);
    check("t2_rdata", d, 32'h00020001);
    check("t2_rresp", r, 2'b00);

    // Partial write
    axil_write(32'h008, 32'hAABBCCDD, 4'hF, r);
    check("t3_resp_full", r, 2'b00);
    axil_write(32'h008, 32'h11223344, 4'b0101, r);
    check("t3_resp_part", r, 2'b00);
    axil_read(32'h008, d, r);
    check("t3_rdata", d, 32'hAA22CC44);

    // Error paths and empty strobe
    tot = stb_total();
    axil_write(32'h000, 32'hDEADBEEF, 4'hF, r);
    check("e_slverr", r, 2'b10);
    check("e_id_kept", cfg_regs[31:0], Id);
    axil_write(32'h020, 32'hDEADBEEF, 4'hF, r);
    check("e_decerr", r, 2'b11);
    check("e_no_stb", stb_total(), tot);
    axil_read(32'h000, d, r);
    check("e_rd_id", {r, d}, {2'b00, Id});
    axil_read(32'h03C, d, r);
    check("e_rd_unmapped", {r, d}, {2'b11, 32'h0});
    axil_write(32'h014, 32'h00001234, 4'h0, r);
    check("e_strb0_resp", r, 2'b00);
    check("e_strb0_data", cfg_regs[191:160], 32'h0);
    check("e_strb0_stb", stb_cnt[5], 1);

    // B back-pressure: second write held behind a pending response
    s_axil_bready = 0;
    s_axil_awaddr = 32'h00C; s_axil_wdata = 32'h33; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(posedge axil_aclk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    @(posedge axil_aclk); #1;
    s_axil_awaddr = 32'h000; s_axil_wdata = 32'h99; s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(negedge axil_aclk);
    check("bp_first_b", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    check("bp_second_ready", {s_axil_awready, s_axil_wready}, 2'b11);
    @(posedge axil_aclk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge axil_aclk);
      check("bp_b_hold", {s_axil_bvalid, s_axil_bresp}, 3'b100);
      check("bp_holds_full", {s_axil_awready, s_axil_wready}, 2'b00);
      @(posedge axil_aclk); #1;
    end
    s_axil_bready = 1;
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("bp_second_b", {s_axil_bvalid, s_axil_bresp}, 3'b110);
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("bp_b_drained", s_axil_bvalid, 1'b0);
    check("bp_reg3", cfg_regs[127:96], 32'h33);
    @(posedge axil_aclk); #1;

    // R back-pressure
    s_axil_rready = 0; s_axil_araddr = 32'h00C; s_axil_arvalid = 1;
    @(posedge axil_aclk); #1;
    s_axil_arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axil_aclk);
      check("rp_hold", {s_axil_rvalid, s_axil_rdata}, {1'b1, 32'h33});
      check("rp_arready", s_axil_arready, 1'b0);
      @(posedge axil_aclk); #1;
    end
    s_axil_rready = 1;
    @(posedge axil_aclk); #1;
    @(negedge axil_aclk);
    check("rp_drained", s_axil_rvalid, 1'b0);
    @(posedge axil_aclk); #1;

    // Reset with AW held and no W
    s_axil_awaddr = 32'h010; s_axil_awvalid = 1;
    @(posedge axil_aclk); #1;
    s_axil_awvalid = 0;
    @(negedge axil_aclk);
    check("mr_aw_held", s_axil_awready, 1'b0);
    @(posedge axil_aclk); #1;
    axil_aresetn = 0;
    #2;
    check("mr_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    check("mr_no_b", s_axil_bvalid, 1'b0);
    check("mr_regs", cfg_regs[127:32], 96'h0);
    @(posedge axil_aclk); #1;
    axil_aresetn = 1;
    @(negedge axil_aclk);
    check("mr_idle", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid}, 4'b1110);
    @(posedge axil_aclk); #1;
    axil_write(32'h010, 32'h44, 4'hF, r);
    check("mr_write_resp", r, 2'b00);
    axil_read(32'h010, d, r);
    check("mr_read_back", d, 32'h44);
    axil_read(32'h004, d, r);
    check("mr_reg1_reset", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
